// File: rtl/alu_cmd_master.sv
// alu_cmd_master: accepts one ALU command at a time, drives the external
// registered ALU for one enable cycle, waits LAT cycles for its result and
// hands the captured result to a valid/ready response port.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | cmd_ready high, waiting for a command
// DRIVE | alu_ena high for exactly one cycle
// WAIT  | counting down to the cycle the ALU result is valid
// RESP  | rsp_valid high, response held until rsp_ready
module alu_cmd_master #(
   parameter int LAT = 1
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       cmd_valid_i,
   output logic       cmd_ready_o,
   input  logic [2:0] cmd_op_i,
   input  logic [7:0] cmd_a_i,
   input  logic [7:0] cmd_b_i,
   output logic [7:0] alu_a_o,
   output logic [7:0] alu_b_o,
   output logic       alu_ena_o,
   input  logic [7:0] alu_y_i,
   input  logic       alu_flag_i,
   output logic       rsp_valid_o,
   input  logic       rsp_ready_i,
   output logic [7:0] rsp_y_o,
   output logic       rsp_flag_o,
   output logic       rsp_err_o,
   output logic [7:0] op_count_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam logic [2:0] OP_RSVD = 3'b111;
   localparam logic [2:0] CNT_LOAD = 3'(LAT - 1);

   state_t     state_q, state_d;
   logic [2:0] op_q, op_d;
   logic [4:0] a_q, a_d;
   logic [7:0] b_q, b_d;
   logic [2:0] cnt_q, cnt_d;
   logic [7:0] rsp_y_q, rsp_y_d;
   logic       rsp_flag_q, rsp_flag_d;
   logic       rsp_err_q, rsp_err_d;
   logic [7:0] op_count_q, op_count_d;

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         op_q       <= 3'd0;
         a_q        <= 5'd0;
         b_q        <= 8'd0;
         cnt_q      <= 3'd0;
         rsp_y_q    <= 8'd0;
         rsp_flag_q <= 1'b0;
         rsp_err_q  <= 1'b0;
         op_count_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         a_q        <= a_d;
         b_q        <= b_d;
         cnt_q      <= cnt_d;
         rsp_y_q    <= rsp_y_d;
         rsp_flag_q <= rsp_flag_d;
         rsp_err_q  <= rsp_err_d;
         op_count_q <= op_count_d;
      end
   end

   // Next-state, datapath updates and per-state outputs.
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      a_d         = a_q;
      b_d         = b_q;
      cnt_d       = cnt_q;
      rsp_y_d     = rsp_y_q;
      rsp_flag_d  = rsp_flag_q;
      rsp_err_d   = rsp_err_q;
      op_count_d  = op_count_q;
      cmd_ready_o = 1'b0;
      alu_ena_o   = 1'b0;
      rsp_valid_o = 1'b0;

      unique case (state_q)
         IDLE: begin
            cmd_ready_o = 1'b1;
            if (cmd_valid_i) begin
               if (cmd_op_i == OP_RSVD) begin
                  // Reserved op never touches the ALU, so its pins keep
                  // whatever the previous command left on them.
                  rsp_y_d    = 8'h00;
                  rsp_flag_d = 1'b0;
                  rsp_err_d  = 1'b1;
                  state_d    = RESP;
               end else begin
                  op_d    = cmd_op_i;
                  a_d     = cmd_a_i[7:3];
                  b_d     = cmd_b_i;
                  state_d = DRIVE;
               end
            end
         end
         DRIVE: begin
            alu_ena_o = 1'b1;
            cnt_d     = CNT_LOAD;
            state_d   = WAIT;
         end
         WAIT: begin
            if (cnt_q == 3'd0) begin
               rsp_y_d    = alu_y_i;
               rsp_flag_d = alu_flag_i;
               rsp_err_d  = 1'b0;
               state_d    = RESP;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         RESP: begin
            rsp_valid_o = 1'b1;
            if (rsp_ready_i) begin
               op_count_d = op_count_q + 8'd1;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign alu_a_o    = {a_q, op_q};
   assign alu_b_o    = b_q;
   assign rsp_y_o    = rsp_y_q;
   assign rsp_flag_o = rsp_flag_q;
   assign rsp_err_o  = rsp_err_q;
   assign op_count_o = op_count_q;

endmodule

// File: tb/tb_alu_cmd_master.sv
// Bench for alu_cmd_master: one instance at LAT=1 for the main scoreboard
// traffic and one at LAT=3 for the longer-latency and mid-WAIT reset cases.
module tb_alu_cmd_master;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] cmd_op;
   logic [7:0] cmd_a, cmd_b;

   logic       cmd_valid1, rsp_ready1;
   logic       cmd_ready1, alu_ena1, rsp_valid1, rsp_flag1, rsp_err1, alu_flag1;
   logic [7:0] alu_a1, alu_b1, alu_y1, rsp_y1, op_count1;

   logic       cmd_valid3, rsp_ready3;
   logic       cmd_ready3, alu_ena3, rsp_valid3, rsp_flag3, rsp_err3, alu_flag3;
   logic [7:0] alu_a3, alu_b3, alu_y3, rsp_y3, op_count3;

   int checks = 0;
   int errors = 0;
   logic [9:0] sb_q[$];

   always #5 clk = ~clk;

   alu_cmd_master #(.LAT(1)) u_dut1 (
      .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid1), .cmd_ready_o(cmd_ready1),
      .cmd_op_i(cmd_op), .cmd_a_i(cmd_a), .cmd_b_i(cmd_b),
      .alu_a_o(alu_a1), .alu_b_o(alu_b1), .alu_ena_o(alu_ena1),
      .alu_y_i(alu_y1), .alu_flag_i(alu_flag1),
      .rsp_valid_o(rsp_valid1), .rsp_ready_i(rsp_ready1),
      .rsp_y_o(rsp_y1), .rsp_flag_o(rsp_flag1), .rsp_err_o(rsp_err1),
      .op_count_o(op_count1));

   alu_cmd_master #(.LAT(3)) u_dut3 (
      .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid3), .cmd_ready_o(cmd_ready3),
      .cmd_op_i(cmd_op), .cmd_a_i(cmd_a), .cmd_b_i(cmd_b),
      .alu_a_o(alu_a3), .alu_b_o(alu_b3), .alu_ena_o(alu_ena3),
      .alu_y_i(alu_y3), .alu_flag_i(alu_flag3),
      .rsp_valid_o(rsp_valid3), .rsp_ready_i(rsp_ready3),
      .rsp_y_o(rsp_y3), .rsp_flag_o(rsp_flag3), .rsp_err_o(rsp_err3),
      .op_count_o(op_count3));

   // ALU behaviour: full alu_a is operand A, alu_a[2:0] selects the function.
   function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b);
      logic [8:0] r;
      case (a[2:0])
         3'd0: r = {1'b0, a} + {1'b0, b};
         3'd1: r = {1'b0, a | b};
         3'd2: r = {1'b0, a & b};
         3'd3: r = {1'b0, ~(a | b)};
         3'd4: r = {1'b0, 8'(a << b[2:0])};
         3'd5: r = {1'b0, a >> b[2:0]};
         3'd6: r = {a < b, 8'(a - b)};
         default: r = 9'd0;
      endcase
      return r;
   endfunction

   // Expected response {err, flag, y} derived from the command alone.
   function automatic logic [9:0] exp_rsp(input logic [2:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
      if (op == 3'b111) return {1'b1, 1'b0, 8'h00};
      return {1'b0, alu_f({a[7:3], op}, b)};
   endfunction

   // Registered ALU models with one and three cycles of latency.
   logic [8:0] p3 [3];
   always @(posedge clk) begin
      {alu_flag1, alu_y1} <= alu_f(alu_a1, alu_b1);
      p3[0] <= alu_f(alu_a3, alu_b3);
      p3[1] <= p3[0];
      p3[2] <= p3[1];
   end
   assign {alu_flag3, alu_y3} = p3[2];

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // One command through the LAT=1 instance; called and returned at a negedge.
   task automatic do_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input int hold);
      logic [9:0] exp;
      logic [7:0] cnt0, a_before, b_before;
      int cyc, ena_cnt;
      a_before = alu_a1;
      b_before = alu_b1;
      chk("cmd_ready_idle", cmd_ready1, 1);
      cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid1 = 1'b1;
      sb_q.push_back(exp_rsp(op, a, b));
      @(negedge clk);
      cmd_valid1 = 1'b0;
      cyc = 1; ena_cnt = 0;
      while (!rsp_valid1 && cyc < 20) begin
         if (alu_ena1) begin
            ena_cnt++;
            chk("alu_a", alu_a1, {a[7:3], op});
            chk("alu_b", alu_b1, b);
         end
         chk("cmd_ready_busy", cmd_ready1, 0);
         @(negedge clk);
         cyc++;
      end
      chk("latency", cyc, (op == 3'b111) ? 1 : 3);
      chk("ena_pulses", ena_cnt, (op == 3'b111) ? 0 : 1);
      if (op == 3'b111) begin
         chk("rsvd_alu_a", alu_a1, a_before);
         chk("rsvd_alu_b", alu_b1, b_before);
      end
      exp = sb_q[0];
      for (int i = 0; i < hold; i++) begin
         chk("hold_valid", rsp_valid1, 1);
         chk("hold_y", rsp_y1, exp[7:0]);
         chk("hold_err", rsp_err1, exp[9]);
         chk("hold_ready", cmd_ready1, 0);
         chk("hold_ena", alu_ena1, 0);
         cmd_op = 3'd1; cmd_a = 8'h5A; cmd_b = 8'h33; cmd_valid1 = 1'b1;
         @(negedge clk);
      end
      cmd_valid1 = 1'b0;
      rsp_ready1 = 1'b1;
      exp = sb_q.pop_front();
      chk("rsp_valid", rsp_valid1, 1);
      chk("rsp_y", rsp_y1, exp[7:0]);
      chk("rsp_flag", rsp_flag1, exp[8]);
      chk("rsp_err", rsp_err1, exp[9]);
      cnt0 = op_count1;
      @(negedge clk);
      rsp_ready1 = 1'b0;
      chk("after_valid", rsp_valid1, 0);
      chk("after_idle", cmd_ready1, 1);
      chk("op_count", op_count1, 8'(cnt0 + 8'd1));
   endtask

   initial begin
      int cyc;
      rst = 1'b1;
      cmd_valid1 = 1'b1; cmd_valid3 = 1'b1;
      rsp_ready1 = 1'b0; rsp_ready3 = 1'b0;
      cmd_op = 3'd0; cmd_a = 8'hFF; cmd_b = 8'h10;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      cmd_valid1 = 1'b0; cmd_valid3 = 1'b0;

      chk("rst_cmd_ready", cmd_ready1, 1);
      chk("rst_alu_a", alu_a1, 8'h00);
      chk("rst_alu_b", alu_b1, 8'h00);
      chk("rst_alu_ena", alu_ena1, 0);
      chk("rst_rsp_valid", rsp_valid1, 0);
      chk("rst_rsp_y", rsp_y1, 8'h00);
      chk("rst_rsp_flag", rsp_flag1, 0);
      chk("rst_rsp_err", rsp_err1, 0);
      chk("rst_op_count", op_count1, 8'h00);
      @(negedge clk);
      chk("rst_no_accept", cmd_ready1, 1);

      do_cmd(3'b000, 8'hFF, 8'h10, 0);
      do_cmd(3'b110, 8'h20, 8'h30, 0);
      do_cmd(3'b111, 8'h55, 8'h00, 0);
      do_cmd(3'b001, 8'hA0, 8'h0C, 5);
      do_cmd(3'b010, 8'hF3, 8'h3C, 1);
      do_cmd(3'b011, 8'h08, 8'h01, 0);
      do_cmd(3'b100, 8'h1C, 8'h03, 0);
      do_cmd(3'b101, 8'hF5, 8'h82, 2);

      // LAT=3 instance: full command, then a reset while it sits in WAIT.
      cmd_op = 3'b000; cmd_a = 8'h30; cmd_b = 8'h40; cmd_valid3 = 1'b1;
      @(negedge clk);
      cmd_valid3 = 1'b0;
      cyc = 1;
      while (!rsp_valid3 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      chk("lat3_latency", cyc, 5);
      chk("lat3_rsp_y", rsp_y3, 8'h70);
      chk("lat3_rsp_flag", rsp_flag3, 0);
      rsp_ready3 = 1'b1;
      @(negedge clk);
      rsp_ready3 = 1'b0;
      chk("lat3_op_count", op_count3, 8'h01);

      cmd_op = 3'b110; cmd_a = 8'h80; cmd_b = 8'h01; cmd_valid3 = 1'b1;
      @(negedge clk);
      cmd_valid3 = 1'b0;
      chk("lat3_drive", alu_ena3, 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midwait_ready", cmd_ready3, 1);
      chk("midwait_ena", alu_ena3, 0);
      chk("midwait_valid", rsp_valid3, 0);
      chk("midwait_count", op_count3, 8'h00);
      rsp_ready3 = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("no_stale_rsp", rsp_valid3, 0);
      end
      rsp_ready3 = 1'b0;

      // The reset above also cleared the LAT=1 instance's op_count.
      chk("wrap_start", op_count1, 8'h00);
      for (int i = 0; i < 256; i++)
         do_cmd(3'(i % 7), 8'(i * 37), 8'(i * 11 + 5), 0);
      chk("wrap_end", op_count1, 8'h00);
      chk("sb_empty", sb_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
